// File: rtl/regset_port_ctrl.sv
// Pipeline-side controller for the 64 x (32+1) register set with synchronous, read-first ports.
// Clears the set after reset, holds read addresses on stalls, forces x0 to zero and forwards same-cycle writes.
module regset_port_ctrl #(
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter bit ZERO_X0        = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        busy,
   input  logic        req_re,
   input  logic [5:0]  req_ra1,
   input  logic [5:0]  req_ra2,
   input  logic        req_we,
   input  logic [5:0]  req_wa,
   input  logic [31:0] req_wd,
   input  logic        req_wg,
   output logic [31:0] op_rd1,
   output logic        op_rg1,
   output logic [31:0] op_rd2,
   output logic        op_rg2,
   output logic        rs_we,
   output logic [5:0]  rs_wa,
   output logic [31:0] rs_wd,
   output logic        rs_wg,
   output logic [5:0]  rs_ra1,
   output logic [5:0]  rs_ra2,
   input  logic [31:0] rs_rd1,
   input  logic        rs_rg1,
   input  logic [31:0] rs_rd2,
   input  logic        rs_rg2
);

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   state_t      state_reg;
   logic [5:0]  cnt_reg;
   logic        busy_reg;
   logic        clearing;

   logic        we_int;
   logic [5:0]  wa_int;
   logic [31:0] wd_int;
   logic        wg_int;

   logic [5:0]  req_ra_a [2];
   logic [5:0]  ra_a     [2];
   logic [31:0] rd_a     [2];
   logic        rg_a     [2];
   logic [31:0] op_d_a   [2];
   logic        op_g_a   [2];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         cnt_reg   <= '0;
         busy_reg  <= CLEAR_ON_RESET;
      end else if (state_reg == ST_CLEAR) begin
         cnt_reg <= cnt_reg + 6'd1;
         if (cnt_reg == 6'd63) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b0;
         end
      end
   end

   assign clearing = (state_reg == ST_CLEAR);
   assign busy     = busy_reg;

   // The clear sequence owns the write port; pipeline writes to x0 never reach the set.
   always_comb begin
      if (clearing) begin
         we_int = 1'b1;
         wa_int = cnt_reg;
         wd_int = '0;
         wg_int = 1'b0;
      end else begin
         we_int = req_we && !(ZERO_X0 && (req_wa == 6'd0));
         wa_int = req_wa;
         wd_int = req_wd;
         wg_int = req_wg;
      end
   end

   assign rs_we = we_int;
   assign rs_wa = wa_int;
   assign rs_wd = wd_int;
   assign rs_wg = wg_int;

   assign req_ra_a[0] = req_ra1;
   assign req_ra_a[1] = req_ra2;
   assign rd_a[0]     = rs_rd1;
   assign rd_a[1]     = rs_rd2;
   assign rg_a[0]     = rs_rg1;
   assign rg_a[1]     = rs_rg2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [5:0]  held_reg;
         logic        fwd_reg;
         logic [31:0] fwd_d_reg;
         logic        fwd_g_reg;
         logic        zero_reg;

         assign ra_a[gi] = req_re ? req_ra_a[gi] : held_reg;

         // The set returns pre-write data on a same-cycle collision, so capture the write instead.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               held_reg  <= '0;
               fwd_reg   <= 1'b0;
               fwd_d_reg <= '0;
               fwd_g_reg <= 1'b0;
               zero_reg  <= 1'b0;
            end else begin
               held_reg  <= ra_a[gi];
               fwd_reg   <= we_int && (wa_int == ra_a[gi]);
               fwd_d_reg <= wd_int;
               fwd_g_reg <= wg_int;
               zero_reg  <= ZERO_X0 && (ra_a[gi] == 6'd0);
            end
         end

         assign op_d_a[gi] = (clearing || zero_reg) ? 32'd0 : (fwd_reg ? fwd_d_reg : rd_a[gi]);
         assign op_g_a[gi] = (clearing || zero_reg) ? 1'b0  : (fwd_reg ? fwd_g_reg : rg_a[gi]);
      end
   endgenerate

   assign rs_ra1 = ra_a[0];
   assign rs_ra2 = ra_a[1];
   assign op_rd1 = op_d_a[0];
   assign op_rg1 = op_g_a[0];
   assign op_rd2 = op_d_a[1];
   assign op_rg2 = op_g_a[1];

endmodule

// File: tb/tb_regset_port_ctrl.sv
// Bench for regset_port_ctrl: a read-first register-set stub plus an architectural register-file
// model that predicts what each read must return one cycle later.
module tb_regset_port_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_re, req_we, req_wg;
   logic [5:0]  req_ra1, req_ra2, req_wa;
   logic [31:0] req_wd;

   logic        busy, op_rg1, op_rg2, rs_we, rs_wg, rs_rg1, rs_rg2;
   logic [31:0] op_rd1, op_rd2, rs_wd, rs_rd1, rs_rd2;
   logic [5:0]  rs_wa, rs_ra1, rs_ra2;

   logic        busy_n, op_rg1_n, op_rg2_n, rs_we_n, rs_wg_n;
   logic [31:0] op_rd1_n, op_rd2_n, rs_wd_n;
   logic [5:0]  rs_wa_n, rs_ra1_n, rs_ra2_n;

   int checks = 0;
   int errors = 0;

   // architectural model
   logic [32:0] ref_mem [64];
   logic [5:0]  ref_h1, ref_h2;
   logic [32:0] exp1, exp2;
   int          busy_left;

   // register-set stub: synchronous read, read-first on collision
   logic [32:0] bram [64];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rs_we) bram[rs_wa] <= {rs_wg, rs_wd};
      {rs_rg1, rs_rd1} <= bram[rs_ra1];
      {rs_rg2, rs_rd2} <= bram[rs_ra2];
   end

   regset_port_ctrl #(.CLEAR_ON_RESET(1'b1), .ZERO_X0(1'b1)) dut (
      .clk(clk), .rstn(rstn), .busy(busy),
      .req_re(req_re), .req_ra1(req_ra1), .req_ra2(req_ra2),
      .req_we(req_we), .req_wa(req_wa), .req_wd(req_wd), .req_wg(req_wg),
      .op_rd1(op_rd1), .op_rg1(op_rg1), .op_rd2(op_rd2), .op_rg2(op_rg2),
      .rs_we(rs_we), .rs_wa(rs_wa), .rs_wd(rs_wd), .rs_wg(rs_wg),
      .rs_ra1(rs_ra1), .rs_ra2(rs_ra2),
      .rs_rd1(rs_rd1), .rs_rg1(rs_rg1), .rs_rd2(rs_rd2), .rs_rg2(rs_rg2)
   );

   regset_port_ctrl #(.CLEAR_ON_RESET(1'b0), .ZERO_X0(1'b1)) dut_nc (
      .clk(clk), .rstn(rstn), .busy(busy_n),
      .req_re(req_re), .req_ra1(req_ra1), .req_ra2(req_ra2),
      .req_we(req_we), .req_wa(req_wa), .req_wd(req_wd), .req_wg(req_wg),
      .op_rd1(op_rd1_n), .op_rg1(op_rg1_n), .op_rd2(op_rd2_n), .op_rg2(op_rg2_n),
      .rs_we(rs_we_n), .rs_wa(rs_wa_n), .rs_wd(rs_wd_n), .rs_wg(rs_wg_n),
      .rs_ra1(rs_ra1_n), .rs_ra2(rs_ra2_n),
      .rs_rd1(32'd0), .rs_rg1(1'b0), .rs_rd2(32'd0), .rs_rg2(1'b0)
   );

   task automatic model_reset();
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      ref_h1 = '0;
      ref_h2 = '0;
      exp1 = '0;
      exp2 = '0;
      busy_left = 64;
   endtask

   task automatic drive(input logic re, input logic [5:0] a1, input logic [5:0] a2,
                        input logic we, input logic [5:0] wa, input logic [31:0] wd, input logic wg);
      @(negedge clk);
      req_re = re; req_ra1 = a1; req_ra2 = a2;
      req_we = we; req_wa = wa; req_wd = wd; req_wg = wg;
      #1;
   endtask

   // Apply this cycle's request to the model, then advance past the next rising edge.
   task automatic tick();
      logic [5:0] e1, e2;
      bit in_clear;
      in_clear = (busy_left > 0);
      e1 = req_re ? req_ra1 : ref_h1;
      e2 = req_re ? req_ra2 : ref_h2;
      ref_h1 = e1;
      ref_h2 = e2;
      if (!in_clear && req_we && req_wa != 6'd0) ref_mem[req_wa] = {req_wg, req_wd};
      if (in_clear) busy_left--;
      exp1 = (busy_left > 0 || e1 == 6'd0) ? 33'd0 : ref_mem[e1];
      exp2 = (busy_left > 0 || e2 == 6'd0) ? 33'd0 : ref_mem[e2];
      @(posedge clk);
      #1;
   endtask

   task automatic run_clear(input string tag);
      for (int i = 0; i < 64; i++) begin
         drive(1'b0, 6'($urandom), 6'($urandom), 1'b1, 6'($urandom), $urandom, 1'b1);
         checks++;
         if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy cyc %0d got %0b want 1", tag, i, busy); end
         checks++;
         if ({rs_we, rs_wa, rs_wd, rs_wg} !== {1'b1, 6'(i), 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s_wport cyc %0d got we=%0b wa=%0d wd=%h wg=%0b want we=1 wa=%0d wd=0 wg=0",
                     tag, i, rs_we, rs_wa, rs_wd, rs_wg, i);
         end
         checks++;
         if ({op_rg1, op_rd1, op_rg2, op_rd2} !== 66'd0) begin
            errors++; $display("FAIL %s_op_zero cyc %0d got %h/%h want 0", tag, i, op_rd1, op_rd2);
         end
         checks++;
         if (busy_n !== 1'b0 || rs_wa_n !== req_wa || rs_we_n !== (req_wa != 6'd0)) begin
            errors++;
            $display("FAIL %s_noclear cyc %0d got busy=%0b we=%0b wa=%0d want busy=0 we=%0b wa=%0d",
                     tag, i, busy_n, rs_we_n, rs_wa_n, (req_wa != 6'd0), req_wa);
         end
         $display("%s cyc %0d busy=%0b rs_wa=%0d", tag, i, busy, rs_wa);
         tick();
      end
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      req_re = 0; req_ra1 = 0; req_ra2 = 0; req_we = 0; req_wa = 0; req_wd = 0; req_wg = 0;
      #2 rstn = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", busy); end
      checks++;
      if ({rs_we, rs_wa, rs_wd, rs_wg} !== {1'b1, 6'd0, 32'd0, 1'b0}) begin
         errors++; $display("FAIL reset_wport got we=%0b wa=%0d wd=%h want we=1 wa=0 wd=0", rs_we, rs_wa, rs_wd);
      end
      checks++;
      if ({op_rd1, op_rd2, op_rg1, op_rg2} !== 66'd0) begin
         errors++; $display("FAIL reset_op got %h/%h want 0", op_rd1, op_rd2);
      end
      checks++;
      if (busy_n !== 1'b0) begin errors++; $display("FAIL reset_busy_noclear got %0b want 0", busy_n); end
      $display("reset busy=%0b busy_noclear=%0b", busy, busy_n);
   endtask

   task automatic test_clear();
      rstn = 1'b1;
      run_clear("clear");
      drive(1'b1, 6'd63, 6'd62, 1'b0, 6'd0, 32'd0, 1'b0);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL clear_done_busy got %0b want 0", busy); end
      tick();
      checks++;
      if ({op_rg1, op_rd1} !== exp1 || {op_rg1, op_rd1} !== 33'd0) begin
         errors++; $display("FAIL clear_read63 got %0b/%h want %0b/%h", op_rg1, op_rd1, exp1[32], exp1[31:0]);
      end
      checks++;
      if ({op_rg2, op_rd2} !== exp2) begin
         errors++; $display("FAIL clear_read62 got %0b/%h want %0b/%h", op_rg2, op_rd2, exp2[32], exp2[31:0]);
      end
      $display("clear read63 op_rd1=%h op_rg1=%0b", op_rd1, op_rg1);
   endtask

   task automatic test_basic();
      drive(1'b0, 6'd0, 6'd0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b1);
      tick();
      drive(1'b1, 6'd5, 6'd6, 1'b0, 6'd0, 32'd0, 1'b0);
      tick();
      checks++;
      if ({op_rg1, op_rd1} !== {1'b1, 32'hDEADBEEF} || {op_rg1, op_rd1} !== exp1) begin
         errors++; $display("FAIL basic_read got %0b/%h want 1/deadbeef", op_rg1, op_rd1);
      end
      checks++;
      if ({op_rg2, op_rd2} !== exp2) begin
         errors++; $display("FAIL basic_read6 got %0b/%h want %0b/%h", op_rg2, op_rd2, exp2[32], exp2[31:0]);
      end
      $display("basic op_rd1=%h op_rg1=%0b", op_rd1, op_rg1);
   endtask

   task automatic test_forward();
      drive(1'b0, 6'd0, 6'd0, 1'b1, 6'd7, 32'h11111111, 1'b1);
      tick();
      drive(1'b1, 6'd7, 6'd7, 1'b1, 6'd7, 32'h12345678, 1'b0);
      tick();
      checks++;
      if ({op_rg1, op_rd1} !== {1'b0, 32'h12345678}) begin
         errors++; $display("FAIL fwd_port1 got %0b/%h want 0/12345678", op_rg1, op_rd1);
      end
      checks++;
      if ({op_rg2, op_rd2} !== {1'b0, 32'h12345678}) begin
         errors++; $display("FAIL fwd_port2 got %0b/%h want 0/12345678", op_rg2, op_rd2);
      end
      $display("forward op_rd1=%h op_rd2=%h", op_rd1, op_rd2);
   endtask

   task automatic test_stall();
      drive(1'b1, 6'd9, 6'd4, 1'b0, 6'd0, 32'd0, 1'b0);
      tick();
      drive(1'b0, 6'd3, 6'd3, 1'b1, 6'd9, 32'hA5A5A5A5, 1'b1);
      checks++;
      if (rs_ra1 !== 6'd9 || rs_ra2 !== 6'd4) begin
         errors++; $display("FAIL stall_hold got ra1=%0d ra2=%0d want 9/4", rs_ra1, rs_ra2);
      end
      tick();
      checks++;
      if ({op_rg1, op_rd1} !== {1'b1, 32'hA5A5A5A5}) begin
         errors++; $display("FAIL stall_read got %0b/%h want 1/a5a5a5a5", op_rg1, op_rd1);
      end
      checks++;
      if ({op_rg2, op_rd2} !== exp2) begin
         errors++; $display("FAIL stall_read2 got %0b/%h want %0b/%h", op_rg2, op_rd2, exp2[32], exp2[31:0]);
      end
      $display("stall rs_ra1=%0d op_rd1=%h", rs_ra1, op_rd1);
   endtask

   task automatic test_x0();
      drive(1'b1, 6'd0, 6'd0, 1'b1, 6'd0, 32'hFFFFFFFF, 1'b1);
      checks++;
      if (rs_we !== 1'b0) begin errors++; $display("FAIL x0_drop got rs_we=%0b want 0", rs_we); end
      tick();
      checks++;
      if ({op_rg1, op_rd1, op_rg2, op_rd2} !== 66'd0) begin
         errors++; $display("FAIL x0_read got %0b/%h %0b/%h want 0", op_rg1, op_rd1, op_rg2, op_rd2);
      end
      $display("x0 rs_we=%0b op_rd1=%h", rs_we, op_rd1);
   endtask

   task automatic test_random(input int n);
      logic [5:0] a1, a2, wa;
      for (int i = 0; i < n; i++) begin
         a1 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
         a2 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
         wa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
         drive(1'($urandom), a1, a2, 1'($urandom), wa, $urandom, 1'($urandom));
         checks++;
         if (rs_we !== (req_we && req_wa != 6'd0) || rs_wa !== req_wa || rs_wd !== req_wd) begin
            errors++;
            $display("FAIL rand_wport %0d got we=%0b wa=%0d wd=%h want we=%0b wa=%0d wd=%h",
                     i, rs_we, rs_wa, rs_wd, (req_we && req_wa != 6'd0), req_wa, req_wd);
         end
         tick();
         checks++;
         if ({op_rg1, op_rd1} !== exp1) begin
            errors++; $display("FAIL rand_op1 %0d got %0b/%h want %0b/%h", i, op_rg1, op_rd1, exp1[32], exp1[31:0]);
         end
         checks++;
         if ({op_rg2, op_rd2} !== exp2) begin
            errors++; $display("FAIL rand_op2 %0d got %0b/%h want %0b/%h", i, op_rg2, op_rd2, exp2[32], exp2[31:0]);
         end
         $display("rand %0d re=%0b ra1=%0d ra2=%0d we=%0b wa=%0d op1=%h op2=%h",
                  i, req_re, req_ra1, req_ra2, req_we, req_wa, op_rd1, op_rd2);
      end
   endtask

   task automatic test_mid_reset();
      rstn = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rstn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0);
         tick();
      end
      checks++;
      if (rs_wa !== 6'd20 || busy !== 1'b1) begin
         errors++; $display("FAIL midrst_cnt20 got wa=%0d busy=%0b want 20/1", rs_wa, busy);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (rs_wa !== 6'd0 || busy !== 1'b1) begin
         errors++; $display("FAIL midrst_async got wa=%0d busy=%0b want 0/1", rs_wa, busy);
      end
      $display("midrst asserted at cnt 20 rs_wa=%0d busy=%0b", rs_wa, busy);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
      run_clear("midrst");
      drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_done got busy=%0b want 0", busy); end
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 64; i++) bram[i] = {1'($urandom), 32'($urandom)};
      test_reset();
      test_clear();
      test_basic();
      test_forward();
      test_stall();
      test_x0();
      test_random(200);
      test_mid_reset();
      test_random(60);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
